// File: rtl/ub_read_streamer_pkg.sv
// Shared constants for the unified-buffer read streamer: default geometry,
// output buffer depth and FSM state encoding.
package ub_read_streamer_pkg;

  localparam int unsigned UB_ADDRESSSIZE = 10;
  localparam int unsigned UB_WORDSIZE    = 160;
  localparam int unsigned UB_BUF_DEPTH   = 2;
  localparam int unsigned UB_CNT_W       = $clog2(UB_BUF_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ub_skid_fifo.sv
// Two-entry shift FIFO; the head register drives the output directly so
// data/valid stay stable while the consumer stalls.
module ub_skid_fifo
  import ub_read_streamer_pkg::*;
#(
  parameter int unsigned W = UB_WORDSIZE + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [W-1:0]        push_data_i,
  input  logic                pop_i,
  output logic [W-1:0]        head_o,
  output logic                valid_o,
  output logic [UB_CNT_W-1:0] count_o
);

  localparam logic [UB_CNT_W-1:0] CNT_FULL = UB_CNT_W'(UB_BUF_DEPTH);

  logic [W-1:0]        head_q, head_d;
  logic [W-1:0]        tail_q, tail_d;
  logic [UB_CNT_W-1:0] count_q, count_d;
  logic                valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // An emptied head is cleared so a stale last tag never lingers on the bus.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + UB_CNT_W'(push_i) - UB_CNT_W'(pop_i);
    if (pop_i) begin
      if (count_q == CNT_FULL) begin
        head_d = tail_q;
        if (push_i) tail_d = push_data_i;
      end else begin
        head_d = push_i ? push_data_i : '0;
      end
    end else if (push_i) begin
      if (count_q == '0) head_d = push_data_i;
      else               tail_d = push_data_i;
    end
    valid_d = (count_d != '0);
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/ub_read_streamer.sv
// Unified-buffer read initiator: walks an address range, one read per cycle,
// and streams words out valid/ready. Optional `UB_RD_STRIDE_EN adds a stride port.
module ub_read_streamer
  import ub_read_streamer_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE = UB_ADDRESSSIZE,
  parameter int unsigned WORDSIZE    = UB_WORDSIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
`ifdef UB_RD_STRIDE_EN
  input  logic [ADDRESSSIZE-1:0] stride,
`endif
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   length,
  output logic                   busy,
  output logic                   done,
  output logic                   sram_write_enable,
  output logic [ADDRESSSIZE-1:0] sram_address,
  input  logic [WORDSIZE-1:0]    sram_data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDSIZE-1:0]    out_data,
  output logic                   out_last
);

  localparam int unsigned RW    = ADDRESSSIZE + 1;
  localparam int unsigned OCC_W = UB_CNT_W + 1;

  logic [1:0]             state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic [ADDRESSSIZE-1:0] step_q, step_d;
  logic [RW-1:0]          remaining_q, remaining_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [WORDSIZE:0]      fifo_head;
  logic                   fifo_valid;
  logic [UB_CNT_W-1:0]    fifo_count;
  logic                   pop_c;
  logic [OCC_W-1:0]       occ_c;
  logic                   issue_c;
  logic [ADDRESSSIZE-1:0] start_step_c;

`ifdef UB_RD_STRIDE_EN
  assign start_step_c = stride;
`else
  assign start_step_c = ADDRESSSIZE'(1);
`endif

  assign pop_c   = fifo_valid & out_ready;
  assign occ_c   = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  // Issue only if the word will still have a free slot when it lands.
  assign issue_c = (state_q == ST_RUN) && (remaining_q != '0) &&
                   (occ_c < (OCC_W'(UB_BUF_DEPTH) + OCC_W'(pop_c)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      step_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      step_q          <= step_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    step_d          = step_q;
    remaining_d     = remaining_q;
    inflight_d      = issue_c;
    inflight_last_d = issue_c && (remaining_q == RW'(1));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          step_d      = start_step_c;
          remaining_d = length;
          state_d     = (length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_c) begin
          remaining_d = remaining_q - RW'(1);
          // Address stays on the final read once the range is exhausted.
          if (remaining_q == RW'(1)) state_d = ST_DRAIN;
          else                       addr_d  = addr_q + step_q;
        end
      end
      ST_DRAIN: begin
        if (pop_c && fifo_head[WORDSIZE]) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  ub_skid_fifo #(
    .W (WORDSIZE + 1)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, sram_data_out}),
    .pop_i       (pop_c),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign busy              = busy_q;
  assign done              = done_q;
  assign sram_write_enable = 1'b0;
  assign sram_address      = addr_q;
  assign out_valid         = fifo_valid;
  assign out_data          = fifo_head[WORDSIZE-1:0];
  assign out_last          = fifo_head[WORDSIZE];

endmodule
